sseg_display_arbiter: RTL and testbench
=======================================

Name: sseg_display_arbiter

Overview:
- Shares the 4-digit seven-segment display between NUM_REQ independent requesters (e.g. clock, counter, debug readout) using round-robin time-slicing.
- Registers the granted requester's 32-bit active-low segment pattern onto o_pattern_n, which drives the display multiplexer's per-digit inputs directly.
- Blanks the display when nobody holds a grant.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- TICK_N, 20: prescaler width; one slice tick every 2^TICK_N clocks (about 10.5 ms at 100 MHz).
- SLICE_TICKS, 100: ticks a grant holds before it may be preempted by a waiting requester (about 1 s).

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_req  in  NUM_REQ  level request; bit k asserted = requester k wants the display.
- i_pattern_n  in  32*NUM_REQ  flattened requester patterns. Requester k occupies bits [32k+31:32k]. Within a pattern, digit d occupies [8d+7:8d], active low.
- o_grant  out  NUM_REQ  one-hot grant, registered; all zero when idle.
- o_pattern_n  out  32  registered pattern to the display mux; digit d at [8d+7:8d], active low.
- o_active  out  1  high while any grant is held.

Behaviour:
- Reset (async assert, sync release): o_grant=0, o_pattern_n=32'hFFFF_FFFF (blank), o_active=0, state=IDLE, last-grant pointer=NUM_REQ-1 (requester 0 wins first), prescaler=0, slice count=0.
- Prescaler: free-running TICK_N-bit counter. tick = one-cycle pulse when the counter wraps to 0. Runs in all states.
- IDLE:
  - o_pattern_n held at all ones.
  - If i_req != 0, pick the first asserted bit searching from (last+1) mod NUM_REQ upward with wrap.
  - Next edge: o_grant = one-hot of the winner, last = winner, slice = 0, state = GRANT.
- GRANT (owner g):
  - Every cycle, o_pattern_n <= i_pattern_n slice of g; live pattern updates appear with 1-cycle latency.
  - On tick, slice increments, saturating at SLICE_TICKS.
  - Release when i_req[g]=0: next edge o_grant=0, o_pattern_n=all ones, state=IDLE. Re-arbitration happens from IDLE on the following cycle; no combinational handoff.
  - Preempt when slice==SLICE_TICKS and any other i_req bit is set: next edge, grant moves directly to the next requester in round-robin order after g. last and o_pattern_n take the new owner's values; slice=0; no blank cycle.
  - Slice expired with no other requester: grant retained, slice stays saturated. Any later competing request preempts on the next edge.
  - If release and preempt conditions hold together, release wins (go to IDLE).
- Latency:
  - Request while IDLE at edge N: o_grant valid after edge N+1.
  - Owner pattern on o_pattern_n after edge N+2, because the first GRANT cycle loads it.
  - Implementations may load the pattern on the grant edge instead. Required maximum: pattern valid no later than 2 edges after request.
- o_active = |o_grant, registered consistently with o_grant.
- Reset asserted mid-grant: immediate return to reset values; pointer returns to NUM_REQ-1.
- Round-robin fairness: with all requesters continuously asserted, grants cycle 0,1,2,3,0,... each lasting exactly SLICE_TICKS ticks, ±1 tick phase for the first slice.
- No latches, no clock gating, and no derived clocks; the prescaler produces an enable only.

Test Plan (TICK_N=2, SLICE_TICKS=3, NUM_REQ=4):
- Reset held low, then released with i_req=0 -> o_grant=0, o_pattern_n=FFFFFFFF, o_active=0 for 20 cycles.
- i_req=4'b0100 with pattern2=12345678 -> o_grant=0100 within 1 edge; o_pattern_n=12345678 within 2 edges; change pattern2 to 87654321 -> output follows 1 cycle later.
- i_req=4'b1111 held constantly -> o_grant sequence 0001,0010,0100,1000,0001. Each grant lasts 12 cycles (3 ticks x 4 clocks), ±4 on the first. No blank cycle between owners.
- Owner 1 alone past slice expiry -> grant held indefinitely. Then assert i_req[3] -> o_grant=1000 on the next edge.
- Owner 0 drops i_req[0] while i_req[2] is set, on the cycle its slice expires -> one cycle of o_grant=0 and o_pattern_n=FFFFFFFF, then o_grant=0100.
- i_reset_n pulsed low mid-grant, asynchronously between edges -> outputs blank and grant cleared immediately. After release with i_req=1111, first grant is 0001.

Source files
------------

// File: rtl/sseg_display_arbiter.sv
// Round-robin, time-sliced arbiter that shares one 4-digit seven-segment
// display between NUM_REQ requesters. The current owner's active-low
// pattern is registered onto o_pattern_n. The display is blanked while no
// requester holds a grant.
module sseg_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TICK_N      = 20,
  parameter int SLICE_TICKS = 100
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [32*NUM_REQ-1:0] i_pattern_n,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [31:0]           o_pattern_n,
  output logic                  o_active
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(SLICE_TICKS + 1);

  localparam logic [SW-1:0]      SLICE_MAX = SW'(SLICE_TICKS);
  localparam logic [IW-1:0]      LAST_RST  = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
  localparam logic [31:0]        BLANK     = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  logic [TICK_N-1:0]        presc_q;
  logic                     tick;
  state_e                   state_q, state_d;
  logic [IW-1:0]            last_q, last_d;
  logic [SW-1:0]            slice_q, slice_d;
  logic [NUM_REQ-1:0]       grant_d;
  logic [31:0]              pattern_d;
  logic [NUM_REQ-1:0]       others;
  logic [IW:0]              pick;
  logic [NUM_REQ-1:0][31:0] pat_arr;

  // Round-robin search: first set bit of req, starting at base+1 and
  // wrapping. Result is {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [IW-1:0]      base);
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(base) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  // Requester k's pattern is simply lane k of the flattened bus.
  assign pat_arr = i_pattern_n;

  // The prescaler only yields an enable; no derived clock exists.
  assign tick = &presc_q;

  // Competing requests, i.e. everyone except the current owner.
  assign others = i_req & ~(ONE << last_q);

  // Free-running slice prescaler; tick marks the edge where it wraps to 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
    end else begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge value of every other flop.
      presc_q <= presc_q + 1'b1;
    end
  end

  // Next-state, next-grant and next-pattern decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    grant_d   = o_grant;
    last_d    = last_q;
    slice_d   = slice_q;
    pattern_d = o_pattern_n;
    pick      = '0;
    case (state_q)
      ST_IDLE: begin
        pattern_d = BLANK;
        grant_d   = '0;
        pick      = rr_pick(i_req, last_q);
        if (pick[IW]) begin
          state_d = ST_GRANT;
          grant_d = ONE << pick[IW-1:0];
          last_d  = pick[IW-1:0];
          slice_d = '0;
        end
      end
      ST_GRANT: begin
        pick = rr_pick(others, last_q);
        if (!i_req[last_q]) begin
          // Release takes priority over preemption; re-arbitrate from IDLE.
          state_d   = ST_IDLE;
          grant_d   = '0;
          pattern_d = BLANK;
          slice_d   = '0;
        end else if (slice_q == SLICE_MAX && pick[IW]) begin
          // Direct handoff to the next waiting requester, no blank cycle.
          grant_d   = ONE << pick[IW-1:0];
          last_d    = pick[IW-1:0];
          pattern_d = pat_arr[pick[IW-1:0]];
          slice_d   = '0;
        end else begin
          pattern_d = pat_arr[last_q];
          if (tick && slice_q != SLICE_MAX) begin
            slice_d = slice_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state and registered outputs; reset blanks the display.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RST;
      slice_q     <= '0;
      o_grant     <= '0;
      o_pattern_n <= BLANK;
      o_active    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      slice_q     <= slice_d;
      o_grant     <= grant_d;
      o_pattern_n <= pattern_d;
      o_active    <= |grant_d;
    end
  end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Scoreboard bench for sseg_display_arbiter (NUM_REQ=4, TICK_N=2,
// SLICE_TICKS=3). Stimulus pushes expected grant changes and timed output
// snapshots; a negedge monitor pops and compares them.
module tb_sseg_display_arbiter;

  localparam int          NUM_REQ     = 4;
  localparam int          TICK_N      = 2;
  localparam int          SLICE_TICKS = 3;
  localparam logic [31:0] BLANK       = 32'hFFFF_FFFF;

  logic                  i_clk     = 1'b0;
  logic                  i_reset_n = 1'b0;
  logic [NUM_REQ-1:0]    i_req     = '0;
  logic [32*NUM_REQ-1:0] i_pattern_n;
  logic [NUM_REQ-1:0]    o_grant;
  logic [31:0]           o_pattern_n;
  logic                  o_active;

  sseg_display_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .TICK_N     (TICK_N),
    .SLICE_TICKS(SLICE_TICKS)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_req      (i_req),
    .i_pattern_n(i_pattern_n),
    .o_grant    (o_grant),
    .o_pattern_n(o_pattern_n),
    .o_active   (o_active)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected grant change, with optional bounds on the ending grant's length.
  typedef struct {
    string      name;
    logic [3:0] grant;
    bit         chk_pat;
    logic [31:0] pat;
    int         min_len;
    int         max_len;
  } gev_t;

  // Expected full output snapshot at a given cycle.
  typedef struct {
    string      name;
    int         due;
    logic [3:0] grant;
    bit         chk_pat;
    logic [31:0] pat;
    logic       active;
  } snap_t;

  gev_t  gq[$];
  snap_t sq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_g(input string n, input logic [3:0] g, input bit cp,
                        input logic [31:0] p, input int mn, input int mx);
    gev_t e;
    e.name = n; e.grant = g; e.chk_pat = cp; e.pat = p; e.min_len = mn; e.max_len = mx;
    gq.push_back(e);
  endtask

  task automatic push_s(input string n, input int dly, input logic [3:0] g,
                        input bit cp, input logic [31:0] p, input logic a);
    snap_t s;
    s.name = n; s.due = cyc + dly; s.grant = g; s.chk_pat = cp; s.pat = p; s.active = a;
    sq.push_back(s);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic drain(input string n, input int budget);
    int k;
    k = 0;
    while ((gq.size() != 0 || sq.size() != 0) && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    check({n, "_drained"}, 32'(gq.size() + sq.size()), 32'd0);
  endtask

  // Monitor: grant-change scoreboard plus timed snapshot checks.
  logic [3:0] prev_grant  = '0;
  int         last_change = 0;
  always @(negedge i_clk) begin : monitor
    gev_t  e;
    snap_t s;
    int    len;
    if (o_grant !== prev_grant) begin
      if (gq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_grant_change @cyc %0d: got %b expected %b", cyc, o_grant, prev_grant);
      end else begin
        e = gq.pop_front();
        check({e.name, "_grant"}, 32'(o_grant), 32'(e.grant));
        check({e.name, "_active"}, 32'(o_active), 32'(|e.grant));
        if (e.chk_pat) check({e.name, "_pattern"}, o_pattern_n, e.pat);
        if (e.max_len >= 0) begin
          len = cyc - last_change;
          n_tests++;
          if (len < e.min_len || len > e.max_len) begin
            n_fail++;
            $display("FAIL %s_length: got %0d cycles expected %0d..%0d", e.name, len, e.min_len, e.max_len);
          end
        end
      end
      last_change = cyc;
      prev_grant  = o_grant;
    end
    while (sq.size() != 0 && sq[0].due <= cyc) begin
      s = sq.pop_front();
      check({s.name, "_grant"}, 32'(o_grant), 32'(s.grant));
      check({s.name, "_active"}, 32'(o_active), 32'(s.active));
      if (s.chk_pat) check({s.name, "_pattern"}, o_pattern_n, s.pat);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat [4];
    pat[0] = 32'hC0F9_A4B0;
    pat[1] = 32'h9992_8280;
    pat[2] = 32'h1234_5678;
    pat[3] = 32'hF880_9098;
    i_pattern_n = {pat[3], pat[2], pat[1], pat[0]};
    i_req       = '0;
    i_reset_n   = 1'b0;

    // Reset state, then 20 idle cycles with no requests.
    @(negedge i_clk);
    push_s("in_reset", 1, 4'b0000, 1'b1, BLANK, 1'b0);
    wait_cyc(2);
    i_reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) push_s("idle_after_reset", i, 4'b0000, 1'b1, BLANK, 1'b0);
    wait_cyc(20);

    // Single requester 2: grant within 1 edge, pattern within 2, live updates.
    i_req = 4'b0100;
    push_g("grant_req2", 4'b0100, 1'b0, 32'h0, -1, -1);
    push_s("req2_grant_1edge", 1, 4'b0100, 1'b0, 32'h0, 1'b1);
    push_s("req2_pat_2edge",   2, 4'b0100, 1'b1, pat[2], 1'b1);
    push_s("req2_pat_hold",    3, 4'b0100, 1'b1, pat[2], 1'b1);
    wait_cyc(3);
    pat[2] = 32'h8765_4321;
    i_pattern_n = {pat[3], pat[2], pat[1], pat[0]};
    push_s("req2_pat_follow", 1, 4'b0100, 1'b1, pat[2], 1'b1);
    wait_cyc(3);

    // Asynchronous reset mid-grant, between clock edges.
    push_g("reset_clears", 4'b0000, 1'b1, BLANK, -1, -1);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_reset_grant",   32'(o_grant), 32'd0);
    check("async_reset_pattern", o_pattern_n, BLANK);
    check("async_reset_active",  32'(o_active), 32'd0);
    i_req = 4'b1111;
    @(negedge i_clk);
    wait_cyc(2);
    push_s("held_in_reset", 1, 4'b0000, 1'b1, BLANK, 1'b0);
    wait_cyc(1);

    // All requesting: 0,1,2,3,0 with 12-cycle slices, no blank between owners.
    i_reset_n = 1'b1;
    push_g("rr_first_0", 4'b0001, 1'b0, 32'h0, -1, -1);
    push_g("rr_1",       4'b0010, 1'b1, pat[1], 8, 16);
    push_g("rr_2",       4'b0100, 1'b1, pat[2], 12, 12);
    push_g("rr_3",       4'b1000, 1'b1, pat[3], 12, 12);
    push_g("rr_wrap_0",  4'b0001, 1'b1, pat[0], 12, 12);
    push_s("rr_first_1edge", 1, 4'b0001, 1'b0, 32'h0, 1'b1);
    drain("rr", 120);

    // Owner 0 drops; requester 1 alone keeps the display past slice expiry.
    i_req = 4'b0010;
    push_g("owner0_release", 4'b0000, 1'b1, BLANK, -1, -1);
    push_g("owner1_alone",   4'b0010, 1'b0, 32'h0, -1, -1);
    push_s("owner1_pend_blank", 1, 4'b0000, 1'b1, BLANK, 1'b0);
    push_s("owner1_grant",      2, 4'b0010, 1'b0, 32'h0, 1'b1);
    push_s("owner1_held",      40, 4'b0010, 1'b1, pat[1], 1'b1);
    wait_cyc(40);

    // Late competitor preempts on the very next edge.
    i_req = 4'b1010;
    push_g("preempt_by_3", 4'b1000, 1'b1, pat[3], 39, 39);
    push_s("preempt_next_edge", 1, 4'b1000, 1'b1, pat[3], 1'b1);
    wait_cyc(2);

    // Owner 0 alone until saturated, then release and new request together.
    i_req = 4'b0001;
    push_g("owner3_release", 4'b0000, 1'b1, BLANK, -1, -1);
    push_g("owner0_alone",   4'b0001, 1'b0, 32'h0, -1, -1);
    wait_cyc(30);
    i_req = 4'b0100;
    push_g("release_wins",    4'b0000, 1'b1, BLANK, -1, -1);
    push_g("after_release_2", 4'b0100, 1'b0, 32'h0, -1, -1);
    push_s("release_blank", 1, 4'b0000, 1'b1, BLANK, 1'b0);
    push_s("rearb_grant2",  2, 4'b0100, 1'b0, 32'h0, 1'b1);
    push_s("rearb_pat2",    3, 4'b0100, 1'b1, pat[2], 1'b1);
    wait_cyc(4);

    i_req = 4'b0000;
    push_g("final_release", 4'b0000, 1'b1, BLANK, -1, -1);
    drain("end", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
